// File: rtl/sha3_row_bus_unpack_fifo.sv
// sha3_row_bus_unpack_fifo
//   Captures whole Keccak states from a 5x5 lane row bus (one-cycle sample
//   strobe, no input backpressure), stores up to DEPTH of them and replays
//   each to a valid/ready consumer as BEATS = 5/ROWS_PER_BEAT beats.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset (control state only)
//   flush         synchronous flush: empties FIFO, clears beat, overflow, drops
//   in_sample     one-cycle strobe, in_rowa..in_rowe valid this cycle
//   in_rowa..e    five rows of five lanes; lane [x] is column x
//   out_valid     head beat presented
//   out_ready     consumer accepts when out_valid && out_ready
//   out_rows      rows of current beat, out_rows[0] is row out_row_idx
//   out_row_idx   index of out_rows[0] (always 0 when ROWS_PER_BEAT=5)
//   out_last      current beat is the final beat of the state
//   overflow      sticky: a sample was dropped on a full FIFO
//   drop_count    saturating count of dropped samples
module sha3_row_bus_unpack_fifo #(
  parameter int LANE_W        = 64,
  parameter int DEPTH         = 2,
  parameter int ROWS_PER_BEAT = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic                                        in_sample,
  input  logic [4:0][LANE_W-1:0]                      in_rowa,
  input  logic [4:0][LANE_W-1:0]                      in_rowb,
  input  logic [4:0][LANE_W-1:0]                      in_rowc,
  input  logic [4:0][LANE_W-1:0]                      in_rowd,
  input  logic [4:0][LANE_W-1:0]                      in_rowe,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [ROWS_PER_BEAT-1:0][4:0][LANE_W-1:0]   out_rows,
  output logic [2:0]                                  out_row_idx,
  output logic                                        out_last,
  output logic                                        overflow,
  output logic [15:0]                                 drop_count
);

  localparam int BEATS = (ROWS_PER_BEAT == 5) ? 1 : 5;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  // A single-entry FIFO still gets a 1-bit pointer; pad the array so the
  // pointer width matches the index range.
  localparam int MEMD  = (DEPTH > 1) ? DEPTH : 2;

  if (!(ROWS_PER_BEAT == 1 || ROWS_PER_BEAT == 5)) begin : g_bad_rpb
    $error("ROWS_PER_BEAT must be 1 or 5");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be >= 1");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [4:0][4:0][LANE_W-1:0] r_mem [MEMD];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic [2:0]                  r_beat;
  logic                        r_overflow;
  logic [15:0]                 r_drop_count;

  logic w_full;
  logic w_fire;
  logic w_pop_last;
  logic w_push;
  logic w_drop;

  assign out_valid   = (r_count != '0);
  assign out_last    = out_valid && (r_beat == 3'(BEATS - 1));
  assign out_row_idx = 3'(int'(r_beat) * ROWS_PER_BEAT);
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

  // Flush suppresses the handshake as well as the sample.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_fire     = out_valid && out_ready && !flush;
  assign w_pop_last = w_fire && out_last;
  assign w_push     = in_sample && !flush && (!w_full || w_pop_last);
  assign w_drop     = in_sample && !flush && w_full && !w_pop_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beat       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beat       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_fire) begin
        if (out_last) begin
          r_beat   <= '0;
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end else begin
          r_beat <= r_beat + 3'd1;
        end
      end
      case ({w_push, w_pop_last})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_inc16(r_drop_count);
      end
    end
  end

  // State storage carries no reset; row a lands at index 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_rowe, in_rowd, in_rowc, in_rowb, in_rowa};
  end

  // Gated to zero when empty so the reset value of out_rows is defined
  // even though storage is not reset.
  always_comb begin
    out_rows = '0;
    if (out_valid) begin
      for (int j = 0; j < ROWS_PER_BEAT; j++) begin
        out_rows[j] = r_mem[r_rd_ptr][3'(int'(r_beat) * ROWS_PER_BEAT + j)];
      end
    end
  end

endmodule

// File: tb/tb_sha3_row_bus_unpack_fifo.sv
// Directed bench for sha3_row_bus_unpack_fifo: three instances cover
// (64b, DEPTH 2, 1 row/beat), (64b, DEPTH 2, 5 rows/beat), (32b, DEPTH 1, 1 row/beat).
module tb_sha3_row_bus_unpack_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0][63:0] rows0 [5];
  logic [4:0][31:0] rows2 [5];

  logic s0, f0, r0, v0, last0, ovf0;
  logic [0:0][4:0][63:0] or0;
  logic [2:0] idx0;
  logic [15:0] dc0;

  logic s1, f1, r1, v1, last1, ovf1;
  logic [4:0][4:0][63:0] or1;
  logic [2:0] idx1;
  logic [15:0] dc1;

  logic s2, f2, r2, v2, last2, ovf2;
  logic [0:0][4:0][31:0] or2;
  logic [2:0] idx2;
  logic [15:0] dc2;

  sha3_row_bus_unpack_fifo #(.LANE_W(64), .DEPTH(2), .ROWS_PER_BEAT(1)) u0 (
    .clk(clk), .rst(rst), .flush(f0), .in_sample(s0),
    .in_rowa(rows0[0]), .in_rowb(rows0[1]), .in_rowc(rows0[2]), .in_rowd(rows0[3]), .in_rowe(rows0[4]),
    .out_valid(v0), .out_ready(r0), .out_rows(or0), .out_row_idx(idx0),
    .out_last(last0), .overflow(ovf0), .drop_count(dc0));

  sha3_row_bus_unpack_fifo #(.LANE_W(64), .DEPTH(2), .ROWS_PER_BEAT(5)) u1 (
    .clk(clk), .rst(rst), .flush(f1), .in_sample(s1),
    .in_rowa(rows0[0]), .in_rowb(rows0[1]), .in_rowc(rows0[2]), .in_rowd(rows0[3]), .in_rowe(rows0[4]),
    .out_valid(v1), .out_ready(r1), .out_rows(or1), .out_row_idx(idx1),
    .out_last(last1), .overflow(ovf1), .drop_count(dc1));

  sha3_row_bus_unpack_fifo #(.LANE_W(32), .DEPTH(1), .ROWS_PER_BEAT(1)) u2 (
    .clk(clk), .rst(rst), .flush(f2), .in_sample(s2),
    .in_rowa(rows2[0]), .in_rowb(rows2[1]), .in_rowc(rows2[2]), .in_rowd(rows2[3]), .in_rowe(rows2[4]),
    .out_valid(v2), .out_ready(r2), .out_rows(or2), .out_row_idx(idx2),
    .out_last(last2), .overflow(ovf2), .drop_count(dc2));

  localparam logic [63:0] A = 64'hA000_0000_0000_0000;
  localparam logic [63:0] B = 64'hB000_0000_0000_0000;
  localparam logic [63:0] C = 64'hC000_0000_0000_0000;
  localparam logic [63:0] D = 64'hD000_0000_0000_0000;
  localparam logic [63:0] E = 64'hE000_0000_0000_0000;

  // Lane value for row y, column x of the state tagged 'base'.
  function automatic logic [63:0] lane(input logic [63:0] base, input int y, input int x);
    return base + 64'((y << 8) | x);
  endfunction

  function automatic bit row_ok0(input logic [63:0] base, input int y);
    for (int x = 0; x < 5; x++) if (or0[0][x] !== lane(base, y, x)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit row_ok2(input logic [63:0] base, input int y);
    for (int x = 0; x < 5; x++) if (or2[0][x] !== 32'(lane(base, y, x))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit state_ok1(input logic [63:0] base);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        if (or1[y][x] !== lane(base, y, x)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_rows(input logic [63:0] base);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        rows0[y][x] = lane(base, y, x);
        rows2[y][x] = 32'(lane(base, y, x));
      end
  endtask

  task automatic do_reset();
    {s0, f0, r0, s1, f1, r1, s2, f2, r2} = '0;
    set_rows(64'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Push one state per cycle on u0 for each base given (count 1..3).
  task automatic push0(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2, input int n);
    logic [63:0] bl [3];
    bl[0] = b0; bl[1] = b1; bl[2] = b2;
    for (int i = 0; i < n; i++) begin
      set_rows(bl[i]);
      s0 = 1'b1;
      @(negedge clk);
    end
    s0 = 1'b0;
  endtask

  // Walk the five beats of one state on u0 with out_ready held high.
  task automatic replay0(input logic [63:0] base, input string tag);
    for (int b = 0; b < 5; b++) begin
      n_tests++;
      if (v0 !== 1'b1 || idx0 !== 3'(b) || last0 !== (b == 4)) begin
        n_fail++;
        $display("FAIL %s beat%0d ctl: got valid=%b idx=%0d last=%b, want valid=1 idx=%0d last=%0d",
                 tag, b, v0, idx0, last0, b, (b == 4));
      end
      n_tests++;
      if (!row_ok0(base, b)) begin
        n_fail++;
        $display("FAIL %s beat%0d data: got lane0=%h, want %h", tag, b, or0[0][0], lane(base, b, 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (v0 !== 1'b0 || last0 !== 1'b0 || idx0 !== 3'd0 || ovf0 !== 1'b0 || dc0 !== 16'd0 || or0 !== '0) begin
      n_fail++;
      $display("FAIL reset_u0: got v=%b last=%b idx=%0d ovf=%b dc=%0d, want all 0", v0, last0, idx0, ovf0, dc0);
    end
    n_tests++;
    if (v1 !== 1'b0 || last1 !== 1'b0 || idx1 !== 3'd0 || ovf1 !== 1'b0 || dc1 !== 16'd0 || or1 !== '0 ||
        v2 !== 1'b0 || last2 !== 1'b0 || idx2 !== 3'd0 || ovf2 !== 1'b0 || dc2 !== 16'd0 || or2 !== '0) begin
      n_fail++;
      $display("FAIL reset_u1u2: got v1=%b last1=%b v2=%b last2=%b dc1=%0d dc2=%0d, want all 0",
               v1, last1, v2, last2, dc1, dc2);
    end
  endtask

  task automatic test_single_state();
    do_reset();
    set_rows(64'd0);
    s0 = 1'b1; r0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    replay0(64'd0, "single");
    n_tests++;
    if (v0 !== 1'b0 || last0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got valid=%b last=%b, want 0 0", v0, last0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push0(A, B, C, 3);
    n_tests++;
    if (ovf0 !== 1'b1 || dc0 !== 16'd1) begin
      n_fail++;
      $display("FAIL ovf_flags: got ovf=%b dc=%0d, want 1 1", ovf0, dc0);
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (v0 !== 1'b1 || idx0 !== 3'd0 || last0 !== 1'b0 || !row_ok0(A, 0)) begin
        n_fail++;
        $display("FAIL ovf_stall%0d: got v=%b idx=%0d lane0=%h, want 1 0 %h", i, v0, idx0, or0[0][0], lane(A, 0, 0));
      end
      @(negedge clk);
    end
    r0 = 1'b1;
    replay0(A, "ovfA");
    replay0(B, "ovfB");
    n_tests++;
    if (v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: got valid=%b, want 0", v0);
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    push0(A, B, C, 2);
    r0 = 1'b1;
    for (int b = 0; b < 4; b++) @(negedge clk);
    n_tests++;
    if (idx0 !== 3'd4 || last0 !== 1'b1) begin
      n_fail++;
      $display("FAIL fpp_last: got idx=%0d last=%b, want 4 1", idx0, last0);
    end
    set_rows(C);
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    n_tests++;
    if (ovf0 !== 1'b0 || dc0 !== 16'd0) begin
      n_fail++;
      $display("FAIL fpp_nodrop: got ovf=%b dc=%0d, want 0 0", ovf0, dc0);
    end
    replay0(B, "fppB");
    replay0(C, "fppC");
    n_tests++;
    if (v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_drained: got valid=%b, want 0", v0);
    end
  endtask

  task automatic test_whole_beats();
    logic [63:0] q[$];
    logic [63:0] base;
    logic [4:0][4:0][63:0] snap;
    bit prev_stall, do_pop, do_push;
    int pushed, popped;
    do_reset();
    prev_stall = 1'b0; snap = '0; pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      n_tests++;
      if (v1 !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL whole_valid cyc%0d: got %b, want %0d", cyc, v1, (q.size() != 0));
      end
      if (v1 === 1'b1 && q.size() != 0) begin
        n_tests++;
        if (last1 !== 1'b1 || idx1 !== 3'd0 || !state_ok1(q[0])) begin
          n_fail++;
          $display("FAIL whole_beat cyc%0d: got last=%b idx=%0d lane00=%h, want 1 0 %h",
                   cyc, last1, idx1, or1[0][0], lane(q[0], 0, 0));
        end
      end
      if (prev_stall) begin
        n_tests++;
        if (or1 !== snap) begin
          n_fail++;
          $display("FAIL whole_stable cyc%0d: got lane00=%h, want %h", cyc, or1[0][0], snap[0][0]);
        end
      end
      r1 = (cyc >= 80) ? 1'b1 : 1'($urandom_range(0, 1));
      do_pop  = (v1 === 1'b1) && r1;
      do_push = (cyc < 60) && (cyc % 3 == 0) && (q.size() < 2 || do_pop);
      base = 64'h4000_0000_0000_0000 + (64'(cyc) << 32);
      if (do_push) set_rows(base);
      s1 = do_push;
      prev_stall = (v1 === 1'b1) && !r1;
      snap = or1;
      @(negedge clk);
      if (do_pop) begin void'(q.pop_front()); popped++; end
      if (do_push) begin q.push_back(base); pushed++; end
    end
    s1 = 1'b0;
    n_tests++;
    if (popped != pushed || pushed < 10 || v1 !== 1'b0 || dc1 !== 16'd0) begin
      n_fail++;
      $display("FAIL whole_score: got pushed=%0d popped=%0d valid=%b drops=%0d, want equal >=10 0 0",
               pushed, popped, v1, dc1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    push0(A, B, C, 3);
    n_tests++;
    if (ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got ovf=%b, want 1", ovf0);
    end
    r0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (idx0 !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_midbeat: got idx=%0d, want 2", idx0);
    end
    set_rows(E);
    f0 = 1'b1; s0 = 1'b1;
    @(negedge clk);
    f0 = 1'b0; s0 = 1'b0;
    n_tests++;
    if (v0 !== 1'b0 || ovf0 !== 1'b0 || dc0 !== 16'd0 || idx0 !== 3'd0 || last0 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b ovf=%b dc=%0d idx=%0d last=%b, want all 0", v0, ovf0, dc0, idx0, last0);
    end
    @(negedge clk);
    n_tests++;
    if (v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: got valid=%b, want 0", v0);
    end
    push0(D, D, D, 1);
    replay0(D, "flushD");
    n_tests++;
    if (v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: got valid=%b, want 0", v0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push0(A, B, C, 3);
    r0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (v0 !== 1'b0 || last0 !== 1'b0 || idx0 !== 3'd0 || ovf0 !== 1'b0 || dc0 !== 16'd0 || or0 !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got v=%b last=%b idx=%0d ovf=%b dc=%0d, want all 0", v0, last0, idx0, ovf0, dc0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (v0 !== 1'b0 || idx0 !== 3'd0) begin
      n_fail++;
      $display("FAIL async_rst_after: got v=%b idx=%0d, want 0 0", v0, idx0);
    end
  endtask

  task automatic test_drop_count();
    do_reset();
    s2 = 1'b1;
    repeat (301) @(negedge clk);
    s2 = 1'b0;
    n_tests++;
    if (dc2 !== 16'd300 || ovf2 !== 1'b1 || v2 !== 1'b1) begin
      n_fail++;
      $display("FAIL drops300: got dc=%0d ovf=%b v=%b, want 300 1 1", dc2, ovf2, v2);
    end
  endtask

  task automatic test_lane32();
    do_reset();
    set_rows(64'd0);
    s2 = 1'b1; r2 = 1'b1;
    @(negedge clk);
    s2 = 1'b0;
    for (int b = 0; b < 5; b++) begin
      n_tests++;
      if (v2 !== 1'b1 || idx2 !== 3'(b) || last2 !== (b == 4) || !row_ok2(64'd0, b)) begin
        n_fail++;
        $display("FAIL lane32 beat%0d: got v=%b idx=%0d last=%b lane0=%h, want 1 %0d %0d %h",
                 b, v2, idx2, last2, or2[0][0], b, (b == 4), 32'(lane(64'd0, b, 0)));
      end
      @(negedge clk);
    end
    n_tests++;
    if (v2 !== 1'b0 || last2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lane32_end: got v=%b last=%b, want 0 0", v2, last2);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_state();
    test_overflow();
    test_full_pop_push();
    test_whole_beats();
    test_flush();
    test_async_reset();
    test_drop_count();
    test_lane32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
